// File: rtl/gate_truth_checker.sv
// Purpose : clocked stimulus/check engine for a two-input combinational gate;
//           walks {in1,in0} = 00,01,10,11, samples gate_out after SETTLE_CYCLES
//           cycles per vector and compares it with the EXPECTED truth table.
// Latency : vector k driven at T0+k*SETTLE_CYCLES, sampled at T0+(k+1)*SETTLE_CYCLES;
//           done pulses in the cycle after edge T0+4*SETTLE_CYCLES.
// Backpressure: none; start is only honoured when no run is in flight.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            launch a run (IDLE, or the edge leaving FINISH)
//   gate_out         output of the gate under test
//   in0, in1         registered gate inputs
//   busy, done       run in progress / one-cycle end-of-run pulse
//   pass             last completed run had no mismatches
//   fail_count       mismatching vectors in current/last run (0..4)
//   fail_index       {in1,in0} of the first mismatch (valid when fail_count != 0)
module gate_truth_checker #(
  parameter logic [3:0] EXPECTED      = 4'b0001,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       in0,
  output logic       in1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_count,
  output logic [1:0] fail_index
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;

  logic       mismatch;
  logic [2:0] fc_next;
  logic       launch;

  assign mismatch = (gate_out != EXPECTED[idx]);
  // Count including the compare happening on this edge, so pass can be
  // registered on the same edge as the last sample.
  assign fc_next  = fail_count + {2'b00, mismatch};
  // A start held through FINISH re-launches on the edge that leaves FINISH,
  // giving back-to-back runs without an extra idle cycle.
  assign launch   = start && ((state == IDLE) || (state == FINISH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      in0        <= 1'b0;
      in1        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= 3'd0;
      fail_index <= 2'd0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        state      <= RUN;
        idx        <= 2'd0;
        in0        <= 1'b0;
        in1        <= 1'b0;
        cnt        <= RELOAD;
        pass       <= 1'b0;
        fail_count <= 3'd0;
        fail_index <= 2'd0;
        busy       <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              if (mismatch) begin
                fail_count <= fc_next;
                if (fail_count == 3'd0) fail_index <= idx;
              end
              if (idx != 2'd3) begin
                idx          <= idx + 2'd1;
                {in1, in0}   <= idx + 2'd1;
                cnt          <= RELOAD;
              end else begin
                // in0/in1 stay at 2'b11 until the next run
                state <= FINISH;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (fc_next == 3'd0);
              end
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
module tb_gate_truth_checker;

  localparam logic [3:0] EXP_TT = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;       // 0: default instance (settle 2), 1: settle-1 instance
  int   mode = 0;         // 0 NOR, 1 AND, 2 stuck-0, 3 ~in0, 4 random table
  logic [3:0] rnd_tt = 4'b0000;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural gates under test
  function automatic logic gate_val(input int m, input logic [3:0] tt,
                                    input logic i1, input logic i0);
    case (m)
      0: return ~(i0 | i1);
      1: return i0 & i1;
      2: return 1'b0;
      3: return ~i0;
      default: return tt[{i1, i0}];
    endcase
  endfunction

  logic a_in0, a_in1, a_busy, a_done, a_pass, a_gate;
  logic [2:0] a_fc;
  logic [1:0] a_fi;
  logic b_in0, b_in1, b_busy, b_done, b_pass, b_gate;
  logic [2:0] b_fc;
  logic [1:0] b_fi;
  logic start_a, start_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign a_gate  = gate_val(mode, rnd_tt, a_in1, a_in0);
  assign b_gate  = gate_val(mode, rnd_tt, b_in1, b_in0);

  gate_truth_checker #(.EXPECTED(EXP_TT), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .gate_out(a_gate),
    .in0(a_in0), .in1(a_in1), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail_count(a_fc), .fail_index(a_fi)
  );

  gate_truth_checker #(.EXPECTED(EXP_TT), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .gate_out(b_gate),
    .in0(b_in0), .in1(b_in1), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail_count(b_fc), .fail_index(b_fi)
  );

  logic [1:0] o_vec;
  logic       o_busy, o_done, o_pass;
  logic [2:0] o_fc;
  logic [1:0] o_fi;
  assign o_vec  = sel ? {b_in1, b_in0} : {a_in1, a_in0};
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_pass = sel ? b_pass : a_pass;
  assign o_fc   = sel ? b_fc   : a_fc;
  assign o_fi   = sel ? b_fi   : a_fi;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vec"},  8'(o_vec),  8'd0);
    check({tag, "_busy"}, 8'(o_busy), 8'd0);
    check({tag, "_done"}, 8'(o_done), 8'd0);
    check({tag, "_pass"}, 8'(o_pass), 8'd0);
    check({tag, "_fc"},   8'(o_fc),   8'd0);
    check({tag, "_fi"},   8'(o_fi),   8'd0);
  endtask

  // style 0: start pulse; 1: start re-pulsed at T0+3; 2: start held through FINISH.
  // launch=0 means the caller already performed edge T0 (back-to-back run).
  task automatic do_run(input bit is_b, input int m, input int style, input bit launch);
    int s, t_end, exp_fc, exp_fi;
    logic [3:0] gt;
    sel  = is_b;
    mode = m;
    s     = is_b ? 1 : 2;
    t_end = 4 * s;
    // Reference: evaluate the gate on every vector and diff with the table
    exp_fc = 0;
    exp_fi = 0;
    for (int k = 0; k < 4; k++) begin
      gt[k] = gate_val(m, rnd_tt, k[1], k[0]);
      if (gt[k] != EXP_TT[k]) begin
        if (exp_fc == 0) exp_fi = k;
        exp_fc++;
      end
    end
    if (launch) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = (style == 2);
    check("t0_vec",  8'(o_vec),  8'd0);
    check("t0_busy", 8'(o_busy), 8'd1);
    check("t0_done", 8'(o_done), 8'd0);
    check("t0_pass", 8'(o_pass), 8'd0);
    check("t0_fc",   8'(o_fc),   8'd0);
    for (int t = 1; t <= t_end; t++) begin
      start = (style == 2) || (style == 1 && t == 3);
      @(posedge clk); #1;
      check("vec",  8'(o_vec),  8'((t < t_end) ? t / s : 3));
      check("busy", 8'(o_busy), 8'(t < t_end));
      check("done", 8'(o_done), 8'(t == t_end));
      if (t == t_end) begin
        check("pass", 8'(o_pass), 8'(exp_fc == 0));
        check("fc",   8'(o_fc),   8'(exp_fc));
        if (exp_fc != 0) check("fi", 8'(o_fi), 8'(exp_fi));
      end
    end
    @(posedge clk); #1;
    if (style == 2) begin
      // Held start relaunches on edge T0 + 4*s + 1
      check("relaunch_busy", 8'(o_busy), 8'd1);
      check("relaunch_vec",  8'(o_vec),  8'd0);
      check("relaunch_fc",   8'(o_fc),   8'd0);
      check("relaunch_done", 8'(o_done), 8'd0);
    end else begin
      check("idle_busy", 8'(o_busy), 8'd0);
      check("idle_done", 8'(o_done), 8'd0);
      check("hold_fc",   8'(o_fc),   8'(exp_fc));
      check("hold_pass", 8'(o_pass), 8'(exp_fc == 0));
    end
  endtask

  initial begin
    #1;
    sel = 1'b0; check_reset_outputs("rst_a");
    sel = 1'b1; check_reset_outputs("rst_b");
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_run(1'b0, 0, 0, 1'b1);   // NOR: pass
    do_run(1'b0, 1, 0, 1'b1);   // AND: fc=2, fi=0
    do_run(1'b0, 2, 0, 1'b1);   // stuck-0: fc=1, fi=0
    do_run(1'b0, 3, 0, 1'b1);   // ~in0: fc=1, fi=2
    do_run(1'b1, 0, 0, 1'b1);   // settle 1, NOR
    do_run(1'b0, 0, 1, 1'b1);   // start re-pulse mid-run ignored
    do_run(1'b0, 1, 2, 1'b1);   // held start: back-to-back, clears result
    do_run(1'b0, 0, 0, 1'b0);

    // Reset mid-run: stuck-0 has already logged one failure by T0+5
    sel = 1'b0; mode = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_fc", 8'(a_fc), 8'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_rst_done", 8'(a_done), 8'd0);
      check("post_rst_busy", 8'(a_busy), 8'd0);
    end
    do_run(1'b0, 0, 0, 1'b1);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      rnd_tt = 4'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
